// File: rtl/board_pkg.sv
// Shared board geometry, cell type and server state encoding for the
// board row server and its cell store.
package board_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int CELL_W  = 16;

    typedef logic [CELL_W-1:0] cell_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        COMMIT,
        CLEAR
    } state_e;

    // Linear cell index, row-major with BOARD_W cells per row.
    function automatic int cell_index(input int y, input int x, input int w);
        return y * w + x;
    endfunction

endpackage

// File: rtl/board_ram.sv
// Single-port cell store: synchronous write enable, registered read of the
// same address. Contents are not reset.
module board_ram #(
    parameter int DEPTH = 200,
    parameter int AW    = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rd_data_q <= mem[addr];
    end

    assign rdata = rd_data_q;

endmodule

// File: rtl/board_row_server.sv
// Serves one board row at a time to the color mapper from the cell store.
// Define BOARD_CLEAR_EN to enable the board-wipe (CLEAR) sequence.
module board_row_server #(
    parameter int BOARD_W = board_pkg::BOARD_W,
    parameter int BOARD_H = board_pkg::BOARD_H,
    parameter int CELL_W  = board_pkg::CELL_W
) (
    input  logic                           Clk,
    input  logic                           reset,
    input  logic                           LD_Row,
    input  logic [7:0]                     rowNum,
    output logic [BOARD_W-1:0][CELL_W-1:0] Row,
    output logic                           rowReady,
    input  logic                           wr_en,
    input  logic [3:0]                     wr_x,
    input  logic [4:0]                     wr_y,
    input  logic [CELL_W-1:0]              wr_data,
    output logic                           wr_ready,
    input  logic                           clear
);

    import board_pkg::*;

    localparam int DEPTH = BOARD_W * BOARD_H;
    localparam int AW    = $clog2(DEPTH);
    localparam int IW    = $clog2(BOARD_W);

    state_e                         state_q, state_d;
    logic                           ld_q, ld_d;
    logic                           ld_prev_q, ld_prev_d;
    logic [7:0]                     row_s_q, row_s_d;
    logic                           pend_q, pend_d;
    logic [7:0]                     pend_row_q, pend_row_d;
    logic                           clr_pend_q, clr_pend_d;
    logic [7:0]                     fetch_row_q, fetch_row_d;
    logic [AW-1:0]                  cnt_q, cnt_d;
    logic                           rd_vld_q, rd_vld_d;
    logic [IW-1:0]                  rd_idx_q, rd_idx_d;
    logic [BOARD_W-1:0][CELL_W-1:0] shadow_q, shadow_d;
    logic [BOARD_W-1:0][CELL_W-1:0] row_q, row_d;
    logic                           row_ready_q, row_ready_d;

    logic                           rise;
    logic                           req_now;
    logic [7:0]                     req_row;
    logic                           clear_req;
    logic                           clr_go;
    logic                           wr_fire;
    logic                           wr_in_range;
    logic                           fetch_oor;
    logic [AW-1:0]                  wr_addr;
    logic [AW-1:0]                  fetch_addr;

    logic                           ram_we;
    logic [AW-1:0]                  ram_addr;
    logic [CELL_W-1:0]              ram_wdata;
    logic [CELL_W-1:0]              ram_rdata;

`ifdef BOARD_CLEAR_EN
    assign clear_req = clear;
`else
    assign clear_req = clear & 1'b0;
`endif

    // A request is a sampled low-to-high step of LD_Row; rowNum was captured on that same edge.
    assign rise    = ld_q & ~ld_prev_q;
    assign req_now = rise | pend_q;
    assign req_row = rise ? row_s_q : pend_row_q;
    assign clr_go  = clear_req | clr_pend_q;

    assign wr_ready    = reset && (state_q == IDLE) && !req_now && !clr_go;
    assign wr_fire     = wr_en && wr_ready;
    assign wr_in_range = (int'(wr_x) < BOARD_W) && (int'(wr_y) < BOARD_H);
    assign wr_addr     = AW'(cell_index(int'(wr_y), int'(wr_x), BOARD_W));

    assign fetch_oor  = int'(fetch_row_q) >= BOARD_H;
    assign fetch_addr = fetch_oor ? '0 : AW'(cell_index(int'(fetch_row_q), int'(cnt_q), BOARD_W));

    always_comb begin
        state_d     = state_q;
        ld_d        = LD_Row;
        ld_prev_d   = ld_q;
        row_s_d     = rowNum;
        pend_d      = pend_q;
        pend_row_d  = pend_row_q;
        clr_pend_d  = clr_pend_q;
        fetch_row_d = fetch_row_q;
        cnt_d       = cnt_q;
        rd_vld_d    = 1'b0;
        rd_idx_d    = cnt_q[IW-1:0];
        shadow_d    = shadow_q;
        row_d       = row_q;
        row_ready_d = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = wr_data;

        // Read data lands one cycle after its address; the last cell arrives during COMMIT.
        if (rd_vld_q) begin
            shadow_d[rd_idx_q] = fetch_oor ? '0 : ram_rdata;
        end

        case (state_q)
            IDLE: begin
                if (req_now) begin
                    state_d     = FETCH;
                    fetch_row_d = req_row;
                    cnt_d       = '0;
                    pend_d      = 1'b0;
                    if (clear_req) begin
                        clr_pend_d = 1'b1;
                    end
                end else if (clr_go) begin
                    state_d    = CLEAR;
                    cnt_d      = '0;
                    clr_pend_d = 1'b0;
                end else if (wr_fire && wr_in_range) begin
                    ram_we   = 1'b1;
                    ram_addr = wr_addr;
                end
            end

            FETCH: begin
                ram_addr = fetch_addr;
                rd_vld_d = 1'b1;
                if (int'(cnt_q) == BOARD_W - 1) begin
                    state_d = COMMIT;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
                if (rise) begin
                    pend_d     = 1'b1;
                    pend_row_d = row_s_q;
                end
                if (clear_req) begin
                    clr_pend_d = 1'b1;
                end
            end

            COMMIT: begin
                row_d       = shadow_d;
                row_ready_d = 1'b1;
                if (clear_req) begin
                    clr_pend_d = 1'b1;
                end
                if (req_now) begin
                    state_d     = FETCH;
                    fetch_row_d = req_row;
                    cnt_d       = '0;
                    pend_d      = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end

            CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = cnt_q;
                ram_wdata = '0;
                if (rise) begin
                    pend_d     = 1'b1;
                    pend_row_d = row_s_q;
                end
                if (int'(cnt_q) == DEPTH - 1) begin
                    if (req_now) begin
                        state_d     = FETCH;
                        fetch_row_d = req_row;
                        cnt_d       = '0;
                        pend_d      = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ld_q        <= 1'b0;
            ld_prev_q   <= 1'b0;
            row_s_q     <= '0;
            pend_q      <= 1'b0;
            pend_row_q  <= '0;
            clr_pend_q  <= 1'b0;
            fetch_row_q <= '0;
            cnt_q       <= '0;
            rd_vld_q    <= 1'b0;
            rd_idx_q    <= '0;
            shadow_q    <= '0;
            row_q       <= '0;
            row_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_q        <= ld_d;
            ld_prev_q   <= ld_prev_d;
            row_s_q     <= row_s_d;
            pend_q      <= pend_d;
            pend_row_q  <= pend_row_d;
            clr_pend_q  <= clr_pend_d;
            fetch_row_q <= fetch_row_d;
            cnt_q       <= cnt_d;
            rd_vld_q    <= rd_vld_d;
            rd_idx_q    <= rd_idx_d;
            shadow_q    <= shadow_d;
            row_q       <= row_d;
            row_ready_q <= row_ready_d;
        end
    end

    board_ram #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (CELL_W)
    ) u_ram (
        .clk  (Clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    assign Row      = row_q;
    assign rowReady = row_ready_q;

endmodule

// File: tb/tb_board_row_server.sv
// Directed self-checking bench for board_row_server at default parameters.
// Exercises the clear sequence when BOARD_CLEAR_EN is defined.
module tb_board_row_server;

    logic              Clk = 1'b0;
    logic              reset = 1'b0;
    logic              LD_Row = 1'b0;
    logic [7:0]        rowNum = '0;
    logic [9:0][15:0]  Row;
    logic              rowReady;
    logic              wr_en = 1'b0;
    logic [3:0]        wr_x = '0;
    logic [4:0]        wr_y = '0;
    logic [15:0]       wr_data = '0;
    logic              wr_ready;
    logic              clear = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_mem [20][10];

    board_row_server dut (
        .Clk     (Clk),
        .reset   (reset),
        .LD_Row  (LD_Row),
        .rowNum  (rowNum),
        .Row     (Row),
        .rowReady(rowReady),
        .wr_en   (wr_en),
        .wr_x    (wr_x),
        .wr_y    (wr_y),
        .wr_data (wr_data),
        .wr_ready(wr_ready),
        .clear   (clear)
    );

    always #5 Clk = ~Clk;

    function automatic logic [9:0][15:0] exp_row(input int y);
        logic [9:0][15:0] r;
        r = '0;
        if (y < 20) begin
            for (int x = 0; x < 10; x++) r[x] = exp_mem[y][x];
        end
        return r;
    endfunction

    // Stimulus helper: one write, waits (bounded) for wr_ready; waited=-1 on timeout.
    task automatic do_write(input int x, input int y, input logic [15:0] d, output int waited);
        @(negedge Clk);
        wr_en = 1'b1; wr_x = 4'(x); wr_y = 5'(y); wr_data = d;
        waited = 0;
        #1;
        while (!wr_ready && waited >= 0) begin
            @(negedge Clk); #1;
            waited++;
            if (waited > 500) waited = -1;
        end
        @(negedge Clk);
        wr_en = 1'b0;
    endtask

    // Stimulus helper: LD_Row rise for row r; lat counts edges after the sampling edge.
    task automatic do_fetch(input int r, output int lat, output logic [9:0][15:0] got,
                            output logic after);
        lat = -1; got = '0;
        @(negedge Clk);
        LD_Row = 1'b1; rowNum = 8'(r);
        @(posedge Clk);
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(negedge Clk); LD_Row = 1'b0;
            @(posedge Clk); #1;
            if (rowReady) begin lat = i; got = Row; end
        end
        @(posedge Clk); #1;
        after = rowReady;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (Row !== '0 || rowReady !== 1'b0 || wr_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: Row=%h rowReady=%b wr_ready=%b, need 0/0/0", Row, rowReady, wr_ready);
        end
        @(negedge Clk); reset = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_wr_ready: got %b need 1", wr_ready);
        end
    endtask

    task automatic test_fill();
        int w, bad;
        bad = 0;
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++) exp_mem[y][x] = '0;
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 10; x++) begin
                exp_mem[y][x] = 16'(y * 256 + x * 16 + 7);
                do_write(x, y, exp_mem[y][x], w);
                if (w != 0) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL fill_accept: %0d writes not accepted at once, need 0", bad);
        end
    endtask

    task automatic test_write_fetch();
        int w, lat;
        logic [9:0][15:0] got;
        logic after;
        do_write(3, 5, 16'h0F00, w);
        exp_mem[5][3] = 16'h0F00;
        do_fetch(5, lat, got, after);
        checks++;
        if (lat != 12) begin
            errors++;
            $display("[TB] FAIL row5_latency: got %0d need 12", lat);
        end
        checks++;
        if (got !== exp_row(5)) begin
            errors++;
            $display("[TB] FAIL row5_data: got %h need %h", got, exp_row(5));
        end
        checks++;
        if (after !== 1'b0) begin
            errors++;
            $display("[TB] FAIL row5_pulse_width: rowReady %b next cycle, need 0", after);
        end
    endtask

    task automatic test_oor_write();
        int w1, w2, lat;
        logic [9:0][15:0] got;
        logic after;
        do_write(12, 5, 16'hFFFF, w1);
        do_write(3, 25, 16'hEEEE, w2);
        checks++;
        if (w1 != 0 || w2 != 0) begin
            errors++;
            $display("[TB] FAIL oor_write_accept: waits %0d/%0d need 0/0", w1, w2);
        end
        do_fetch(6, lat, got, after);
        checks++;
        if (got !== exp_row(6)) begin
            errors++;
            $display("[TB] FAIL oor_write_row6: got %h need %h", got, exp_row(6));
        end
        do_fetch(5, lat, got, after);
        checks++;
        if (got !== exp_row(5)) begin
            errors++;
            $display("[TB] FAIL oor_write_row5: got %h need %h", got, exp_row(5));
        end
    endtask

    task automatic test_oor_row();
        int lat;
        logic [9:0][15:0] got;
        logic after;
        do_fetch(25, lat, got, after);
        checks++;
        if (lat != 12 || got !== '0) begin
            errors++;
            $display("[TB] FAIL row25: lat %0d row %h, need 12 and zero", lat, got);
        end
        do_fetch(20, lat, got, after);
        checks++;
        if (lat != 12 || got !== '0) begin
            errors++;
            $display("[TB] FAIL row20: lat %0d row %h, need 12 and zero", lat, got);
        end
    endtask

    task automatic test_pending();
        int hits;
        int hit_cyc [4];
        logic [9:0][15:0] hit_row [4];
        hits = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge Clk);
            LD_Row = (i == 0 || i == 3 || i == 5 || i == 7);
            if (i == 0) rowNum = 8'd1;
            if (i == 3) rowNum = 8'd2;
            if (i == 5) rowNum = 8'd7;
            if (i == 7) rowNum = 8'd9;
            @(posedge Clk); #1;
            if (rowReady && hits < 4) begin
                hit_cyc[hits] = i; hit_row[hits] = Row; hits++;
            end
        end
        checks++;
        if (hits != 2) begin
            errors++;
            $display("[TB] FAIL pending_count: %0d rows served, need 2", hits);
        end else begin
            checks++;
            if (hit_cyc[0] != 12 || hit_row[0] !== exp_row(1)) begin
                errors++;
                $display("[TB] FAIL pending_first: cyc %0d row %h, need 12 %h", hit_cyc[0], hit_row[0], exp_row(1));
            end
            checks++;
            if (hit_cyc[1] != 23 || hit_row[1] !== exp_row(9)) begin
                errors++;
                $display("[TB] FAIL pending_second: cyc %0d row %h, need 23 %h", hit_cyc[1], hit_row[1], exp_row(9));
            end
        end
    endtask

    task automatic test_write_during_fetch();
        int first_rdy, accepts, lat;
        logic [9:0][15:0] seen, got;
        logic after;
        first_rdy = -1; accepts = 0; lat = -1; seen = '0;
        @(negedge Clk);
        LD_Row = 1'b1; rowNum = 8'd4;
        @(posedge Clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            LD_Row = 1'b0;
            if (accepts > 0) wr_en = 1'b0;
            if (i == 0) begin wr_en = 1'b1; wr_x = 4'd0; wr_y = 5'd4; wr_data = 16'h0ABC; end
            #1;
            if (wr_en && wr_ready) begin
                accepts++;
                if (first_rdy < 0) first_rdy = i;
            end
            @(posedge Clk); #1;
            if (rowReady && lat < 0) begin lat = i + 1; seen = Row; end
        end
        checks++;
        if (first_rdy != 12 || accepts != 1) begin
            errors++;
            $display("[TB] FAIL wr_hold: first ready cycle %0d accepts %0d, need 12 and 1", first_rdy, accepts);
        end
        checks++;
        if (lat != 12 || seen !== exp_row(4)) begin
            errors++;
            $display("[TB] FAIL wr_hold_row4_old: lat %0d row %h, need 12 %h", lat, seen, exp_row(4));
        end
        exp_mem[4][0] = 16'h0ABC;
        do_fetch(4, lat, got, after);
        checks++;
        if (got !== exp_row(4)) begin
            errors++;
            $display("[TB] FAIL wr_hold_row4_new: got %h need %h", got, exp_row(4));
        end
    endtask

`ifdef BOARD_CLEAR_EN
    task automatic test_clear();
        int low, lat;
        logic rdy_end, rdy_req;
        logic [9:0][15:0] got;
        logic after;
        low = 0;
        @(negedge Clk); clear = 1'b1;
        #1; rdy_req = wr_ready;
        @(negedge Clk); clear = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!wr_ready) low++;
            @(negedge Clk);
        end
        #1; rdy_end = wr_ready;
        checks++;
        if (rdy_req !== 1'b0 || low != 200 || rdy_end !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_wr_ready: req %b low %0d end %b, need 0 200 1", rdy_req, low, rdy_end);
        end
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++) exp_mem[y][x] = '0;
        do_fetch(0, lat, got, after);
        checks++;
        if (lat != 12 || got !== '0) begin
            errors++;
            $display("[TB] FAIL clear_row0: lat %0d row %h, need 12 zero", lat, got);
        end
    endtask
`else
    task automatic test_clear();
        int lat;
        logic r0, r1;
        logic [9:0][15:0] got;
        logic after;
        @(negedge Clk); clear = 1'b1;
        #1; r0 = wr_ready;
        @(negedge Clk); clear = 1'b0;
        #1; r1 = wr_ready;
        checks++;
        if (r0 !== 1'b1 || r1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_ignored_ready: %b %b, need 1 1", r0, r1);
        end
        do_fetch(0, lat, got, after);
        checks++;
        if (lat != 12 || got !== exp_row(0)) begin
            errors++;
            $display("[TB] FAIL clear_ignored_row0: lat %0d row %h, need 12 %h", lat, got, exp_row(0));
        end
    endtask
`endif

    task automatic test_reset_mid_fetch();
        int w, lat, spurious;
        logic [9:0][15:0] got;
        logic after;
        do_write(0, 5, 16'h1234, w);
        exp_mem[5][0] = 16'h1234;
        do_fetch(5, lat, got, after);
        checks++;
        if (got !== exp_row(5)) begin
            errors++;
            $display("[TB] FAIL pre_reset_row5: got %h need %h", got, exp_row(5));
        end
        @(negedge Clk); LD_Row = 1'b1; rowNum = 8'd5;
        @(posedge Clk);
        @(negedge Clk); LD_Row = 1'b0;
        repeat (4) @(negedge Clk);
        reset = 1'b0;
        #1;
        checks++;
        if (Row !== '0 || rowReady !== 1'b0 || wr_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_fetch_reset: Row=%h rowReady=%b wr_ready=%b, need 0/0/0", Row, rowReady, wr_ready);
        end
        @(negedge Clk); reset = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_fetch_idle: wr_ready %b need 1", wr_ready);
        end
        spurious = 0;
        repeat (20) begin
            @(posedge Clk); #1;
            if (rowReady) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("[TB] FAIL mid_fetch_no_pulse: %0d pulses need 0", spurious);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_fetch();
        test_oor_write();
        test_oor_row();
        test_pending();
        test_write_during_fetch();
        test_clear();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
